rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Shares the register file's single write port between several writeback sources (ALU, LSU, MDU). Each source hands its result over through a valid/ready handshake into a one-entry holding buffer. A round-robin arbiter selects one full buffer per cycle and drives a registered write onto the register file write port (`w_valid`/`w_ad`/`w_data`). The register file has no backpressure, so the block sustains one write per cycle with fair, starvation-free ordering.

## Interface
Parameters:
- `NREQ`, default 3: number of writeback requesters, minimum 2; index 0 = ALU, 1 = LSU, 2 = MDU.
- `xlen`: data width, taken from `cpu_parameters`; not overridden locally.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  NREQ  requester i has a result.
- `req_ad`  in  NREQ x 5  destination register of requester i.
- `req_data`  in  NREQ x xlen  result data of requester i.
- `req_ready`  out  NREQ  buffer i can accept this cycle.
- `w_valid`  out  1  register file write enable.
- `w_ad`  out  5  register file write address.
- `w_data`  out  xlen  register file write data.
- `busy`  out  1  OR of all buffer-full flags and `w_valid`; high while any accepted write is not yet committed.

## Operation
- Per requester: holding buffer {`full_i`, `ad_i`, `data_i`}.
- Ready rule: `req_ready[i] = !full_i | grant[i]`, combinational.
- Transfer rule: a transfer occurs when `req_valid[i] & req_ready[i]`. The buffer loads `req_ad[i]`/`req_data[i]` and `full_i <= 1`.
- Arbitration: round-robin pointer `ptr` (width clog2(NREQ)). The first full buffer at or after `ptr`, modulo NREQ, is granted. At most one grant per cycle.
- After a grant to requester i: `ptr <= (i+1) mod NREQ`, wrapping NREQ-1 to 0. If nothing is granted, `ptr` holds.
- Granted buffer: `full_i <= 0` unless a new transfer into buffer i happens in the same cycle. In that case the buffer reloads and `full_i` stays 1, so there is no bubble.
- Output register: on a grant, `w_valid <= 1` and `w_ad`/`w_data` load from the granted buffer. Otherwise `w_valid <= 0` and `w_ad`/`w_data` hold their values.
- Ordering: writes from a single requester commit in acceptance order. The block guarantees no ordering between different requesters; dispatch-side hazard tracking resolves same-address conflicts.

## Timing
- Latency: handshake at edge N, grant during cycle N+1, `w_valid` high in cycle N+2. Minimum is 2 cycles and is fixed.
- Throughput: one write per cycle in aggregate, and one accept per cycle per requester while it is being granted every cycle.
- Worst-case wait for a full buffer: NREQ-1 grants before its own.
- Reset, asynchronous, immediate:
  - all `full_i = 0`, `ptr = 0`;
  - `w_valid = 0`, `w_ad = 0`, `w_data = 0`, `busy = 0`;
  - `req_ready` = all ones while `rst_n` is high, forced to 0 while `rst_n` is low.
- Reset mid-operation drops all buffered and in-flight writes without committing them.
- All outputs except `req_ready` are driven directly from flops.

## Configuration
- `RF_WARB_X0_FILTER_EN` defined:
  - a transfer with `req_ad[i] == 0` is accepted (`req_ready` rule unchanged) but does not set `full_i`;
  - it never reaches the write port and never consumes a grant.
- `RF_WARB_X0_FILTER_EN` undefined:
  - x0 writes are arbitrated and emitted like any other;
  - the register file discards them.

## Test plan
- Single ALU write, `ad=5`, `data=0xDEADBEEF`, accepted at edge 0 -> `w_valid=1`, `w_ad=5`, `w_data=0xDEADBEEF` in cycle 2 only; `busy` high cycles 1-2.
- All three requesters valid at edge 0 (ads 1, 2, 3), `ptr=0` -> writes to 1, 2, 3 on cycles 2, 3, 4; final `ptr=0`.
- ALU and MDU hold `req_valid` continuously with new ads each accept -> grants alternate 0, 2, 0, 2. `w_valid` stays high every cycle, and neither requester waits more than 1 grant.
- ALU granted and re-offering in the same cycle -> `req_ready[0]=1` throughout; back-to-back writes with no bubble.
- Assert `rst_n=0` while LSU and MDU buffers are full and `w_valid=1` -> immediately `w_valid=0` and `busy=0`. After release, no stale write appears and `ptr=0`.
- With `RF_WARB_X0_FILTER_EN`, an LSU write to `ad=0` -> accepted, `w_valid` stays 0, `busy` stays 0. Without the macro -> `w_valid=1`, `w_ad=0` in cycle 2.

Source files
------------

// File: rtl/cpu_parameters.sv
// Core-wide parameters shared by datapath blocks.
package cpu_parameters;
  parameter int xlen = 32;
endpackage

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register file write port among NREQ writeback sources.
// Optional feature: define RF_WARB_X0_FILTER_EN to drop x0 writes at the holding buffers.
module rf_write_arbiter
  import cpu_parameters::*;
#(
  parameter int NREQ = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0][4:0]       req_ad,
  input  logic [NREQ-1:0][xlen-1:0]  req_data,
  output logic [NREQ-1:0]            req_ready,
  output logic                       w_valid,
  output logic [4:0]                 w_ad,
  output logic [xlen-1:0]            w_data,
  output logic                       busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]           full;
  logic [NREQ-1:0]           full_next;
  logic [NREQ-1:0]           grant;
  logic [NREQ-1:0]           xfer;
  logic [NREQ-1:0]           load;
  logic [NREQ-1:0][4:0]      buf_ad;
  logic [NREQ-1:0][xlen-1:0] buf_data;
  logic [PTR_W-1:0]          ptr;
  logic [PTR_W-1:0]          ptr_next;
  logic [PTR_W-1:0]          gnt_idx;
  logic                      gnt_any;
  logic [PTR_W-1:0]          order [NREQ];

  // Search order starts at the round-robin pointer and wraps modulo NREQ.
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      order[k] = PTR_W'((int'(ptr) + k) % NREQ);
    end
  end

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_any && full[order[k]]) begin
        gnt_any = 1'b1;
        gnt_idx = order[k];
      end
    end
    grant[gnt_idx] = gnt_any;
  end

  // A granted buffer drains this cycle, so it may refill on the same edge.
  assign req_ready = {NREQ{rst_n}} & (~full | grant);
  assign xfer      = req_valid & req_ready;

`ifdef RF_WARB_X0_FILTER_EN
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      load[i] = xfer[i] & (req_ad[i] != 5'd0);
    end
  end
`else
  assign load = xfer;
`endif

  assign full_next = (full & ~grant) | load;
  assign ptr_next  = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full    <= '0;
      ptr     <= '0;
      w_valid <= 1'b0;
      w_ad    <= '0;
      w_data  <= '0;
      busy    <= 1'b0;
    end else begin
      full    <= full_next;
      w_valid <= gnt_any;
      busy    <= (|full_next) | gnt_any;
      if (gnt_any) begin
        ptr    <= ptr_next;
        w_ad   <= buf_ad[gnt_idx];
        w_data <= buf_data[gnt_idx];
      end
    end
  end

  // Payload is qualified by full, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (xfer[i]) begin
        buf_ad[i]   <= req_ad[i];
        buf_data[i] <= req_data[i];
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a queue-level reference model compared every cycle.
module tb_rf_write_arbiter;
  import cpu_parameters::*;

  localparam int NREQ = 3;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0][4:0]      req_ad;
  logic [NREQ-1:0][xlen-1:0] req_data;
  logic [NREQ-1:0]           req_ready;
  logic                      w_valid;
  logic [4:0]                w_ad;
  logic [xlen-1:0]           w_data;
  logic                      busy;

  int n_vec = 0;
  int n_bad = 0;

  rf_write_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ad(req_ad),
    .req_data(req_data), .req_ready(req_ready), .w_valid(w_valid),
    .w_ad(w_ad), .w_data(w_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: one pending result per source, pointer as a plain integer.
  bit              m_full [NREQ];
  logic [4:0]      m_ad   [NREQ];
  logic [xlen-1:0] m_data [NREQ];
  int              m_ptr;
  logic            m_wv;
  logic [4:0]      m_wad;
  logic [xlen-1:0] m_wdata;
  logic            m_busy;

  function automatic int pick();
    int i;
    for (int k = 0; k < NREQ; k++) begin
      i = (m_ptr + k) % NREQ;
      if (m_full[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] model_ready();
    logic [NREQ-1:0] r;
    int g;
    g = pick();
    for (int i = 0; i < NREQ; i++) r[i] = rst_n && (!m_full[i] || g == i);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) m_full[i] = 1'b0;
    m_ptr = 0; m_wv = 1'b0; m_wad = '0; m_wdata = '0; m_busy = 1'b0;
  endtask

  task automatic model_step();
    logic [NREQ-1:0] take;
    int g;
    bit any;
    take = req_valid & model_ready();
    g = pick();
    m_wv = (g >= 0);
    if (g >= 0) begin
      m_wad = m_ad[g]; m_wdata = m_data[g];
      m_full[g] = 1'b0;
      m_ptr = (g + 1) % NREQ;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (take[i]) begin
        m_ad[i] = req_ad[i]; m_data[i] = req_data[i];
`ifdef RF_WARB_X0_FILTER_EN
        if (req_ad[i] != 5'd0) m_full[i] = 1'b1;
`else
        m_full[i] = 1'b1;
`endif
      end
    end
    any = 1'b0;
    for (int i = 0; i < NREQ; i++) any |= m_full[i];
    m_busy = any | m_wv;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("cmp_w_valid", 64'(w_valid), 64'(m_wv));
      chk("cmp_w_ad", 64'(w_ad), 64'(m_wad));
      chk("cmp_w_data", 64'(w_data), 64'(m_wdata));
      chk("cmp_busy", 64'(busy), 64'(m_busy));
      chk("cmp_req_ready", 64'(req_ready), 64'(model_ready()));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  logic [NREQ-1:0] rdy;

  initial begin
    req_valid = '0; req_ad = '0; req_data = '0;
    cyc(); cyc();
    chk("rst_w_valid", 64'(w_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_w_ad", 64'(w_ad), 64'd0);
    chk("rst_w_data", 64'(w_data), 64'd0);
    chk("rst_ready_low", 64'(req_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready_high", 64'(req_ready), 64'b111);

    // Single ALU write
    req_valid[0] = 1'b1; req_ad[0] = 5'd5; req_data[0] = 32'hDEADBEEF;
    cyc();
    req_valid = '0;
    chk("t1_c1_wv", 64'(w_valid), 64'd0);
    chk("t1_c1_busy", 64'(busy), 64'd1);
    cyc();
    chk("t1_c2_wv", 64'(w_valid), 64'd1);
    chk("t1_c2_ad", 64'(w_ad), 64'd5);
    chk("t1_c2_data", 64'(w_data), 64'hDEADBEEF);
    chk("t1_c2_busy", 64'(busy), 64'd1);
    cyc();
    chk("t1_c3_wv", 64'(w_valid), 64'd0);
    chk("t1_c3_busy", 64'(busy), 64'd0);

    // All three requesters at once from ptr 0
    do_reset();
    req_valid = 3'b111;
    for (int i = 0; i < NREQ; i++) begin
      req_ad[i] = 5'(i + 1); req_data[i] = 32'h100 + 32'(i);
    end
    cyc();
    req_valid = '0;
    chk("t2_c1_wv", 64'(w_valid), 64'd0);
    for (int c = 2; c <= 4; c++) begin
      cyc();
      chk("t2_wv", 64'(w_valid), 64'd1);
      chk("t2_ad", 64'(w_ad), 64'(c - 1));
      chk("t2_data", 64'(w_data), 64'(32'h100 + 32'(c - 2)));
    end
    cyc();
    chk("t2_idle_wv", 64'(w_valid), 64'd0);
    chk("t2_model_ptr", 64'(m_ptr), 64'd0);

    // ALU and MDU streaming: grants alternate 0,2,0,2
    req_ad[0] = 5'd8; req_ad[2] = 5'd16;
    req_data[0] = 32'hA08; req_data[2] = 32'hC16;
    req_valid = 3'b101;
    for (int c = 1; c <= 9; c++) begin
      rdy = req_ready;
      cyc();
      if (rdy[0]) begin req_ad[0] = req_ad[0] + 5'd1; req_data[0] = req_data[0] + 32'd1; end
      if (rdy[2]) begin req_ad[2] = req_ad[2] + 5'd1; req_data[2] = req_data[2] + 32'd1; end
      if (c >= 2) begin
        chk("t3_wv", 64'(w_valid), 64'd1);
        if (c % 2 == 0) chk("t3_ad_alu", 64'(w_ad), 64'(8 + (c - 2) / 2));
        else            chk("t3_ad_mdu", 64'(w_ad), 64'(16 + (c - 3) / 2));
      end
    end
    req_valid = '0;
    repeat (4) cyc();
    chk("t3_drain_busy", 64'(busy), 64'd0);

    // ALU alone, re-offering while granted: no bubble
    req_ad[0] = 5'd20; req_data[0] = 32'h2000;
    req_valid = 3'b001;
    for (int c = 1; c <= 7; c++) begin
      rdy = req_ready;
      chk("t4_ready0", 64'(req_ready[0]), 64'd1);
      cyc();
      if (rdy[0]) begin req_ad[0] = req_ad[0] + 5'd1; req_data[0] = req_data[0] + 32'd1; end
      if (c >= 2) begin
        chk("t4_wv", 64'(w_valid), 64'd1);
        chk("t4_ad", 64'(w_ad), 64'(20 + c - 2));
      end
    end
    req_valid = '0;
    repeat (3) cyc();

    // Reset with LSU/MDU full and a write in flight
    do_reset();
    req_valid = 3'b111; req_ad[0] = 5'd4; req_ad[1] = 5'd6; req_ad[2] = 5'd7;
    cyc();
    req_valid = '0;
    cyc();
    chk("t5_pre_wv", 64'(w_valid), 64'd1);
    chk("t5_pre_ad", 64'(w_ad), 64'd4);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_wv", 64'(w_valid), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_ready", 64'(req_ready), 64'd0);
    cyc();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cyc();
      chk("t5_stale_wv", 64'(w_valid), 64'd0);
      chk("t5_stale_busy", 64'(busy), 64'd0);
    end
    req_valid = 3'b111; req_ad[0] = 5'd9; req_ad[1] = 5'd10; req_ad[2] = 5'd11;
    cyc();
    req_valid = '0;
    cyc();
    chk("t5_ptr0_first", 64'(w_ad), 64'd9);
    cyc();
    chk("t5_ptr0_second", 64'(w_ad), 64'd10);
    repeat (3) cyc();

    // LSU write to x0
    req_valid = 3'b010; req_ad[1] = 5'd0; req_data[1] = 32'h55;
    chk("t6_ready1", 64'(req_ready[1]), 64'd1);
    cyc();
    req_valid = '0;
`ifdef RF_WARB_X0_FILTER_EN
    chk("t6_c1_busy", 64'(busy), 64'd0);
    cyc();
    chk("t6_c2_wv", 64'(w_valid), 64'd0);
    chk("t6_c2_busy", 64'(busy), 64'd0);
`else
    chk("t6_c1_busy", 64'(busy), 64'd1);
    cyc();
    chk("t6_c2_wv", 64'(w_valid), 64'd1);
    chk("t6_c2_ad", 64'(w_ad), 64'd0);
    chk("t6_c2_data", 64'(w_data), 64'h55);
`endif
    repeat (2) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
